// File: rtl/mioc_pkg.sv
// Shared types and constants for the MEM-stage memory/IO controller.
// Imported by the controller top and its address decoder.
package mioc_pkg;

    typedef enum logic [1:0] {
        MIOC_IDLE = 2'b00,
        MIOC_BUSY = 2'b01,
        MIOC_RESP = 2'b10
    } mioc_state_e;

    localparam logic [31:0] MIOC_WIN_END = 32'h8000_0000;
    localparam int          MIOC_CNT_W   = 16;

endpackage

// File: rtl/mioc_region_decode.sv
// Combinational IO-window decode: window hit, mapped-channel hit
// and channel index for the current MEM-stage address.
module mioc_region_decode
    import mioc_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                NUM_IO       = 4,
    parameter logic [ADDR_W-1:0] IO_BASE      = ADDR_W'(32'h7000_0000),
    parameter int                IO_SPAN_LOG2 = 24,
    parameter int                CH_W         = $clog2(NUM_IO)
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic              o_mapped,
    output logic [CH_W-1:0]   o_ch
);

    localparam logic [ADDR_W-1:0] WIN_END = ADDR_W'(MIOC_WIN_END);
    localparam logic [ADDR_W-1:0] MAP_END =
        IO_BASE + (ADDR_W'(NUM_IO) << IO_SPAN_LOG2);

    logic [ADDR_W-1:0] w_off;

    assign w_off    = i_addr - IO_BASE;
    assign o_hit    = (i_addr >= IO_BASE) && (i_addr < WIN_END);
    assign o_mapped = o_hit && (i_addr < MAP_END);
    assign o_ch     = CH_W'(w_off >> IO_SPAN_LOG2);

endmodule

// File: rtl/mioc_multi_io.sv
// MEM-stage memory/IO controller: RAM passes through, IO channels
// use a req/ack handshake with timeout; faults surface as busErr.
module mioc_multi_io
    import mioc_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int                NUM_IO       = 4,
    parameter logic [ADDR_W-1:0] IO_BASE      = ADDR_W'(32'h7000_0000),
    parameter int                IO_SPAN_LOG2 = 24,
    parameter int                TIMEOUT      = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memCe,
    input  logic                     memWr,
    input  logic [ADDR_W-1:0]        memAddr,
    input  logic [DATA_W-1:0]        wtData,
    output logic [DATA_W-1:0]        rdData,
    output logic                     stall,
    output logic                     busErr,
    output logic                     ramCe,
    output logic                     ramWe,
    output logic [ADDR_W-1:0]        ramAddr,
    output logic [DATA_W-1:0]        ramWtData,
    input  logic [DATA_W-1:0]        ramRdData,
    output logic [NUM_IO-1:0]        ioReq,
    output logic                     ioWe,
    output logic [ADDR_W-1:0]        ioAddr,
    output logic [DATA_W-1:0]        ioWtData,
    input  logic [NUM_IO-1:0]        ioAck,
    input  logic [NUM_IO*DATA_W-1:0] ioRdData
);

    localparam int CH_W = $clog2(NUM_IO);

    mioc_state_e             r_state;
    mioc_state_e             w_next;
    logic [MIOC_CNT_W-1:0]   r_cnt;
    logic [CH_W-1:0]         r_ch;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_wr;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_err;

    logic                    w_hit;
    logic                    w_mapped;
    logic [CH_W-1:0]         w_ch;
    logic                    w_ack;
    logic                    w_tmo;

    mioc_region_decode #(
        .ADDR_W       (ADDR_W),
        .NUM_IO       (NUM_IO),
        .IO_BASE      (IO_BASE),
        .IO_SPAN_LOG2 (IO_SPAN_LOG2),
        .CH_W         (CH_W)
    ) u_decode (
        .i_addr   (memAddr),
        .o_hit    (w_hit),
        .o_mapped (w_mapped),
        .o_ch     (w_ch)
    );

    assign w_ack = ioAck[r_ch];
    assign w_tmo = (r_cnt == MIOC_CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MIOC_IDLE;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                MIOC_IDLE: begin
                    if (memCe && w_hit) begin
                        r_err   <= !w_mapped;
                        r_rdata <= '0;
                        r_cnt   <= '0;
                        if (w_mapped) begin
                            r_ch    <= w_ch;
                            r_addr  <= memAddr;
                            r_wr    <= memWr;
                            r_wdata <= wtData;
                        end
                    end
                end
                MIOC_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Ack beats a coincident timeout.
                    if (w_ack) begin
                        r_rdata <= r_wr ? '0 : ioRdData[r_ch*DATA_W +: DATA_W];
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end
                end
                MIOC_RESP: r_err <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        rdData    = '0;
        stall     = 1'b0;
        busErr    = 1'b0;
        ramCe     = 1'b0;
        ramWe     = 1'b0;
        ramAddr   = '0;
        ramWtData = '0;
        ioReq     = '0;
        ioWe      = 1'b0;
        ioAddr    = '0;
        ioWtData  = '0;
        unique case (r_state)
            MIOC_IDLE: begin
                if (memCe && !w_hit) begin
                    ramCe     = 1'b1;
                    ramWe     = memWr;
                    ramAddr   = memAddr;
                    ramWtData = wtData;
                    rdData    = ramRdData;
                end else if (memCe) begin
                    stall  = 1'b1;
                    w_next = w_mapped ? MIOC_BUSY : MIOC_RESP;
                end
            end
            MIOC_BUSY: begin
                ioReq[r_ch] = 1'b1;
                ioWe        = r_wr;
                ioAddr      = r_addr;
                ioWtData    = r_wdata;
                stall       = 1'b1;
                if (w_ack || w_tmo) w_next = MIOC_RESP;
            end
            MIOC_RESP: begin
                rdData = r_rdata;
                busErr = r_err;
                w_next = MIOC_IDLE;
            end
            default: w_next = MIOC_IDLE;
        endcase
        // Reset is asynchronous, so outputs are squashed combinationally too.
        if (rst) begin
            rdData    = '0;
            stall     = 1'b0;
            busErr    = 1'b0;
            ramCe     = 1'b0;
            ramWe     = 1'b0;
            ramAddr   = '0;
            ramWtData = '0;
            ioReq     = '0;
            ioWe      = 1'b0;
            ioAddr    = '0;
            ioWtData  = '0;
        end
    end

endmodule

// File: tb/tb_mioc_multi_io.sv
// Directed bench for mioc_multi_io: RAM pass-through, IO handshakes,
// timeout, unmapped window, stray ack and mid-access reset.
module tb_mioc_multi_io;

    logic         clk = 1'b0;
    logic         rst;
    logic         memCe;
    logic         memWr;
    logic [31:0]  memAddr;
    logic [31:0]  wtData;
    logic [31:0]  rdData;
    logic         stall;
    logic         busErr;
    logic         ramCe;
    logic         ramWe;
    logic [31:0]  ramAddr;
    logic [31:0]  ramWtData;
    logic [31:0]  ramRdData;
    logic [3:0]   ioReq;
    logic         ioWe;
    logic [31:0]  ioAddr;
    logic [31:0]  ioWtData;
    logic [3:0]   ioAck;
    logic [127:0] ioRdData;

    int n_chk  = 0;
    int n_pass = 0;

    int          r_stalls;
    int          r_reqs;
    logic [31:0] r_rd;
    logic        r_err;
    logic [3:0]  r_req1;
    logic        r_we1;
    logic [31:0] r_addr1;
    logic [31:0] r_wd1;
    logic [31:0] r_addrN;
    logic        r_ram_seen;

    always #5 clk = ~clk;

    mioc_multi_io #(
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .memCe     (memCe),
        .memWr     (memWr),
        .memAddr   (memAddr),
        .wtData    (wtData),
        .rdData    (rdData),
        .stall     (stall),
        .busErr    (busErr),
        .ramCe     (ramCe),
        .ramWe     (ramWe),
        .ramAddr   (ramAddr),
        .ramWtData (ramWtData),
        .ramRdData (ramRdData),
        .ioReq     (ioReq),
        .ioWe      (ioWe),
        .ioAddr    (ioAddr),
        .ioWtData  (ioWtData),
        .ioAck     (ioAck),
        .ioRdData  (ioRdData)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one IO access from IDLE; ack_after=0 means never ack.
    task automatic io_run(input logic [31:0] addr, input logic wr,
                          input logic [31:0] wd, input int ack_after,
                          input int ack_ch, input logic [31:0] ack_data);
        bit done = 0;
        memCe = 1'b1;
        memWr = wr;
        memAddr = addr;
        wtData = wd;
        ioAck = '0;
        ioRdData = {4{32'hFFFF_FFFF}};
        ioRdData[ack_ch*32 +: 32] = ack_data;
        r_stalls = 0;
        r_reqs = 0;
        r_ram_seen = 1'b0;
        r_req1 = '0;
        r_we1 = 1'b0;
        r_addr1 = '0;
        r_wd1 = '0;
        r_addrN = '0;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (ramCe) r_ram_seen = 1'b1;
            if (!stall) begin
                r_rd = rdData;
                r_err = busErr;
                done = 1;
                break;
            end
            r_stalls++;
            if (ioReq != '0) begin
                r_reqs++;
                r_addrN = ioAddr;
                if (r_reqs == 1) begin
                    r_req1 = ioReq;
                    r_we1 = ioWe;
                    r_addr1 = ioAddr;
                    r_wd1 = ioWtData;
                    memAddr = 32'h0000_0040;
                end
                if (ack_after > 0 && r_reqs == ack_after)
                    ioAck = 4'(1 << ack_ch);
            end
            @(posedge clk);
            #1;
            ioAck = '0;
            #1;
        end
        if (!done) begin
            chk("stall_bound", 32'(r_stalls), 32'd0);
            r_rd = 32'hX;
            r_err = 1'bx;
        end
    endtask

    task automatic after_resp(input string tag);
        tick();
        #1;
        chk({tag, "_err_pulse"}, 32'(busErr), 32'd0);
        memCe = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        memCe = 1'b1;
        memWr = 1'b1;
        memAddr = 32'h0000_0100;
        wtData = 32'h1111_2222;
        ramRdData = 32'hDEAD_BEEF;
        ioAck = '0;
        ioRdData = '0;
        repeat (2) tick();
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ramCe", 32'(ramCe), 32'd0);
        chk("rst_rdData", rdData, 32'd0);
        chk("rst_ramAddr", ramAddr, 32'd0);
        chk("rst_ioReq", 32'(ioReq), 32'd0);
        chk("rst_busErr", 32'(busErr), 32'd0);
        tick();
        rst = 1'b0;
        memCe = 1'b0;
        tick();

        memCe = 1'b1;
        memWr = 1'b0;
        memAddr = 32'h0000_0100;
        #1;
        chk("ram_rd_data", rdData, 32'hDEAD_BEEF);
        chk("ram_rd_stall", 32'(stall), 32'd0);
        chk("ram_rd_ioReq", 32'(ioReq), 32'd0);
        chk("ram_rd_ce", 32'(ramCe), 32'd1);
        chk("ram_rd_we", 32'(ramWe), 32'd0);
        chk("ram_rd_addr", ramAddr, 32'h0000_0100);
        tick();
        memWr = 1'b1;
        memAddr = 32'h0000_0200;
        wtData = 32'hA5A5_0F0F;
        #1;
        chk("ram_wr_we", 32'(ramWe), 32'd1);
        chk("ram_wr_data", ramWtData, 32'hA5A5_0F0F);
        chk("ram_wr_addr", ramAddr, 32'h0000_0200);
        tick();
        memCe = 1'b0;
        tick();

        io_run(32'h7100_0004, 1'b1, 32'hCAFE_F00D, 3, 1, 32'h9999_9999);
        chk("iow_req", 32'(r_req1), 32'h2);
        chk("iow_we", 32'(r_we1), 32'd1);
        chk("iow_addr", r_addr1, 32'h7100_0004);
        chk("iow_wdata", r_wd1, 32'hCAFE_F00D);
        chk("iow_addr_held", r_addrN, 32'h7100_0004);
        chk("iow_stalls", 32'(r_stalls), 32'd4);
        chk("iow_err", 32'(r_err), 32'd0);
        chk("iow_rd", r_rd, 32'd0);
        chk("iow_ram", 32'(r_ram_seen), 32'd0);
        after_resp("iow");

        io_run(32'h7300_0000, 1'b0, 32'h0, 2, 3, 32'h1234_5678);
        chk("ior_req", 32'(r_req1), 32'h8);
        chk("ior_we", 32'(r_we1), 32'd0);
        chk("ior_rd", r_rd, 32'h1234_5678);
        chk("ior_stalls", 32'(r_stalls), 32'd3);
        chk("ior_err", 32'(r_err), 32'd0);
        after_resp("ior");

        io_run(32'h7200_0010, 1'b0, 32'h0, 0, 2, 32'h7777_7777);
        chk("tmo_req", 32'(r_req1), 32'h4);
        chk("tmo_reqs", 32'(r_reqs), 32'd8);
        chk("tmo_stalls", 32'(r_stalls), 32'd9);
        chk("tmo_err", 32'(r_err), 32'd1);
        chk("tmo_rd", r_rd, 32'd0);
        after_resp("tmo");

        io_run(32'h7200_0000, 1'b0, 32'h0, 8, 2, 32'h0000_55AA);
        chk("race_rd", r_rd, 32'h0000_55AA);
        chk("race_err", 32'(r_err), 32'd0);
        chk("race_stalls", 32'(r_stalls), 32'd9);
        after_resp("race");

        io_run(32'h7400_0000, 1'b0, 32'h0, 0, 0, 32'h0);
        chk("unm_stalls", 32'(r_stalls), 32'd1);
        chk("unm_reqs", 32'(r_reqs), 32'd0);
        chk("unm_ram", 32'(r_ram_seen), 32'd0);
        chk("unm_err", 32'(r_err), 32'd1);
        chk("unm_rd", r_rd, 32'd0);
        after_resp("unm");

        io_run(32'h7000_0000, 1'b0, 32'h0, 1, 2, 32'h3333_3333);
        chk("stray_req", 32'(r_req1), 32'h1);
        chk("stray_reqs", 32'(r_reqs), 32'd8);
        chk("stray_err", 32'(r_err), 32'd1);
        chk("stray_rd", r_rd, 32'd0);
        after_resp("stray");

        memCe = 1'b1;
        memWr = 1'b0;
        memAddr = 32'h7100_0000;
        tick();
        tick();
        #1;
        chk("mid_busy_req", 32'(ioReq), 32'h2);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(ioReq), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        tick();
        rst = 1'b0;
        memAddr = 32'h0000_0300;
        #1;
        chk("post_rst_ramCe", 32'(ramCe), 32'd1);
        chk("post_rst_stall", 32'(stall), 32'd0);
        tick();
        memCe = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
